fixed_div: RTL and testbench
============================

# fixed_div

Sequential unsigned fixed-point divider for the Q16.16 datapath. It is the inverse of the team's combinational Q16.16 multiplier. It computes `quotient = (dividend << FRAC) / divisor` by restoring long division, one quotient bit per clock. A start/busy/done handshake connects it to the control FSM. Divide-by-zero and quotient overflow are flagged, and the result saturates in both cases.

## Interface
- `WIDTH`, 32: operand and result width in bits.
- `FRAC`, 16: fraction bits. The format is Q(WIDTH-FRAC).FRAC.

One clock. Reset is asynchronous and active-low.

- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: request a division. Sampled only when `busy`=0.
- `A`  in  WIDTH: dividend, Q16.16 unsigned. Sampled on the accepting edge.
- `B`  in  WIDTH: divisor, Q16.16 unsigned. Sampled on the accepting edge.
- `result`  out  WIDTH: quotient, Q16.16, truncated toward zero.
- `busy`  out  1: high while state is RUN.
- `done`  out  1: one-cycle pulse; `result` and the flags are valid from this cycle onward.
- `div_by_zero`  out  1: the last operation had `B`=0.
- `overflow`  out  1: the true quotient exceeded WIDTH bits.

## Operation
- States:
  - IDLE: reset state.
  - RUN: iterating.
  - DONE: one cycle; drives `done`=1.
- Accept: `start`=1 in IDLE or DONE.
  - If `B`≠0: load dividend register `{A, FRAC'b0}` (48 bits), divisor `B`, remainder 0, counter = WIDTH+FRAC-1 = 47, and go to RUN.
  - If `B`=0: go straight to DONE with `result`=all-ones, `div_by_zero`=1, `overflow`=0.
- RUN, per cycle:
  - Shift the dividend MSB into the remainder (WIDTH+1 bits wide).
  - Trial-subtract the divisor. If it does not borrow, keep the difference and the quotient bit is 1. Otherwise restore and the quotient bit is 0.
  - Shift the quotient bit into the 48-bit quotient register and decrement the counter.
- Last step (counter = 0): go to DONE.
  - If quotient[47:32]≠0: `result`=all-ones and `overflow`=1.
  - Otherwise `result`=quotient[31:0] and `overflow`=0.
  - `div_by_zero`=0.
- DONE → IDLE next cycle unless `start`=1, which gives a back-to-back accept.
- `start` in RUN is ignored; it is neither queued nor able to corrupt the operation.
- `result` and the flags hold their values until the next completion, so they stay stable through IDLE and a following RUN.
- Reset at any time, including mid-RUN, aborts the operation. All registers return to their reset values and no `done` is produced.

## Timing
- Reset values:
  - state IDLE
  - `result`=0
  - `busy`=0
  - `done`=0
  - `div_by_zero`=0
  - `overflow`=0
  - counter=0
- Latency for `B`≠0:
  - `start` is accepted on edge k.
  - `busy`=1 from after edge k through edge k+48.
  - `done`=1 in the cycle after edge k+48, which is 48 cycles of latency.
- Latency for `B`=0: `done`=1 in the cycle after edge k.
- `done` and `busy` are never high together.
- Throughput: one division every 49 cycles when `start` is held high.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package `fixed_pkg` holds:
  - `WIDTH_C`=32 and `FRAC_C`=16
  - `typedef logic [31:0] fix_t`
  - the divider state enum `div_state_t {IDLE, RUN, DONE}`
  - the saturation constant `FIX_MAX`=32'hFFFF_FFFF
- One sub-module, `div_step`: a combinational restoring step.
  - Inputs: remainder, next dividend bit, divisor.
  - Outputs: new remainder and quotient bit.
- Top-level `fixed_div` holds the FSM, counter and shift registers.

## Test plan
- Reset, then A=0x0001_0000, B=0x0001_0000, start → after 48 cycles `done`=1, `result`=0x0001_0000, both flags 0.
- A=0x0003_0000, B=0x0002_0000 → `result`=0x0001_8000. A=0x0001_0000, B=0x0003_0000 → `result`=0x0000_5555 (truncated).
- B=0 with any A → `done` on the next cycle, `result`=0xFFFF_FFFF, `div_by_zero`=1, `overflow`=0.
- A=0x7FFF_0000, B=0x0000_0001 → `overflow`=1, `result`=0xFFFF_FFFF. A=0x0000_0000, B=0x1234_5678 → `result`=0, no flags.
- Pulse `start` with different operands during RUN → ignored; the first result is correct and the second `start` is not taken. Hold `start` through DONE → back-to-back accept, 49-cycle period.
- Assert `rst_n`=0 at cycle 20 of RUN → all outputs return to reset values immediately. No `done` follows. A fresh start after release completes correctly.

Source files
------------

// File: rtl/fixed_pkg.sv
// Shared Q16.16 fixed-point definitions used by the arithmetic blocks.
package fixed_pkg;
    localparam int WIDTH_C = 32;
    localparam int FRAC_C  = 16;

    typedef logic [31:0] fix_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    localparam fix_t FIX_MAX = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] dvs_i,
    output logic [W:0]   rem_o,
    output logic         q_o
);
    logic [W+1:0] shifted;
    logic [W+1:0] diff;

    // rem_i < dvs_i always holds, so shifted fits in W+1 bits and diff's MSB is the borrow
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {2'b00, dvs_i};
    assign q_o     = ~diff[W+1];
    assign rem_o   = q_o ? diff[W:0] : shifted[W:0];
endmodule

// File: rtl/fixed_div.sv
// Sequential unsigned Q(WIDTH-FRAC).FRAC divider, one quotient bit per clock.
module fixed_div
    import fixed_pkg::*;
#(
    parameter int WIDTH = WIDTH_C,
    parameter int FRAC  = FRAC_C
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int TOT = WIDTH + FRAC;
    localparam int CW  = $clog2(TOT);

    div_state_t       state_q, state_d;
    logic [TOT-1:0]   dvd_q, dvd_d;
    logic [TOT-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   rem_nxt;
    logic             q_bit;
    logic [TOT-1:0]   quo_fin;

    div_step #(.W(WIDTH)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[TOT-1]),
        .dvs_i (dvs_q),
        .rem_o (rem_nxt),
        .q_o   (q_bit)
    );

    assign quo_fin = {quo_q[TOT-2:0], q_bit};

    always_comb begin
        state_d  = state_q;
        dvd_d    = dvd_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;
        case (state_q)
            RUN: begin
                dvd_d = {dvd_q[TOT-2:0], 1'b0};
                rem_d = rem_nxt;
                quo_d = quo_fin;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    dbz_d   = 1'b0;
                    // Any set bit above WIDTH means the true quotient does not fit
                    if (quo_fin[TOT-1:WIDTH] != '0) begin
                        result_d = '1;
                        ovf_d    = 1'b1;
                    end else begin
                        result_d = quo_fin[WIDTH-1:0];
                        ovf_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                if (start) begin
                    if (B != '0) begin
                        state_d = RUN;
                        dvd_d   = {A, {FRAC{1'b0}}};
                        dvs_d   = B;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = CW'(TOT - 1);
                    end else begin
                        state_d  = DONE;
                        result_d = '1;
                        dbz_d    = 1'b1;
                        ovf_d    = 1'b0;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dvd_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dvd_q    <= dvd_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result      = result_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_fixed_div.sv
// Scoreboard bench for fixed_div: expected results queued at accept, checked on done.
module tb_fixed_div;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A, B;
    logic [31:0] result;
    logic        busy, done, div_by_zero, overflow;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        logic        ovf;
        time         t_done;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    fixed_div dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .result      (result),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input time t_acc);
        exp_t        e;
        logic [63:0] q;
        if (b == 32'd0) begin
            e.res = 32'hFFFF_FFFF; e.dbz = 1'b1; e.ovf = 1'b0;
            e.t_done = t_acc + 5;
        end else begin
            q = ({32'd0, a} << 16) / {32'd0, b};
            e.dbz = 1'b0;
            e.ovf = (q > 64'h0000_0000_FFFF_FFFF);
            e.res = e.ovf ? 32'hFFFF_FFFF : q[31:0];
            e.t_done = t_acc + 48 * 10 + 5;
        end
        return e;
    endfunction

    // Wait for an accepting cycle, present the operands, queue the expectation
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input bit keep, output time t_acc);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("accept_timeout", 1, 0);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        t_acc = $time;
        sb.push_back(model(a, b, t_acc));
        #1;
        if (!keep) start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("div_by_zero", div_by_zero, e.dbz);
                chk("overflow", overflow, e.ovf);
                chk("latency", $time, e.t_done);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    initial begin
        time t0, t1, t2;
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_flags", {busy, done, div_by_zero, overflow}, 0);
        rst_n = 1'b1;

        drive(32'h0001_0000, 32'h0001_0000, 0, t0);
        drain();
        drive(32'h0003_0000, 32'h0002_0000, 0, t0);
        drive(32'h0001_0000, 32'h0003_0000, 0, t0);
        drive(32'hDEAD_BEEF, 32'h0000_0000, 0, t0);
        drive(32'h7FFF_0000, 32'h0000_0001, 0, t0);
        drive(32'h0000_0000, 32'h1234_5678, 0, t0);
        drain();
        chk("hold_result", result, 0);

        for (int i = 0; i < 6; i++) begin
            drive($urandom, $urandom >> (i * 5), 0, t0);
        end
        drain();

        // Start with new operands while running must be ignored
        drive(32'h0005_0000, 32'h0002_0000, 0, t0);
        repeat (10) @(negedge clk);
        A = 32'h1111_1111;
        B = 32'h0000_0003;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        // Held start gives back-to-back accepts
        drive(32'h0009_0000, 32'h0004_0000, 1, t0);
        drive(32'h0009_0000, 32'h0004_0000, 1, t1);
        drive(32'h0009_0000, 32'h0004_0000, 0, t2);
        chk("period_1", t1 - t0, 490);
        chk("period_2", t2 - t1, 490);
        drain();

        // Reset mid-run aborts with no completion
        drive(32'h0002_0000, 32'h0003_0000, 0, t0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_result", result, 0);
        chk("abort_flags", {busy, done, div_by_zero, overflow}, 0);
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("abort_idle", {busy, done}, 0);
        drive(32'h0006_0000, 32'h0004_0000, 0, t0);
        drain();

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
